// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner with a double-buffered frame.
// Optional anti-ghost dead time per slot is enabled by defining SEVEN_SEG_GHOST_BLANK_EN.
module seven_segment_scanner #(
  parameter int clk_mhz      = 50,
  parameter int w_digit      = 8,
  parameter int slot_khz     = 1,
  parameter int blank_cycles = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [w_digit*8-1:0]   in_segments,
  input  logic                   in_valid,
  input  logic                   enable,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_start
);

  localparam int slot_cycles = clk_mhz * 1000 / slot_khz;
  localparam int cnt_w       = $clog2(slot_cycles);
  localparam int idx_w       = ($clog2(w_digit) < 1) ? 1 : $clog2(w_digit);

  if (blank_cycles >= slot_cycles) begin : g_bad_blank
    $error("blank_cycles must be smaller than slot_cycles");
  end

  logic [cnt_w-1:0]       cnt;
  logic [idx_w-1:0]       idx;
  logic [w_digit*8-1:0]   pending;
  logic [w_digit*8-1:0]   shadow;
  logic [w_digit*8-1:0]   shadow_next;
  logic                   pending_flag;
  logic                   terminal;
  logic                   frame_first;
  logic                   show;
  logic [7:0]             seg_sel;
  logic [w_digit-1:0]     digit_sel;

  assign terminal    = (cnt == cnt_w'(slot_cycles - 1));
  // The cycle in which the scan sits at slot 0 / count 0 is the frame boundary.
  assign frame_first = (cnt == '0) && (idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (terminal) begin
      cnt <= '0;
      idx <= (idx == idx_w'(w_digit - 1)) ? '0 : idx + idx_w'(1);
    end else begin
      cnt <= cnt + cnt_w'(1);
    end
  end

  // A strobe in the boundary cycle bypasses straight into the displayed frame.
  always_comb begin
    shadow_next = shadow;
    if (frame_first) begin
      if (in_valid) begin
        shadow_next = in_segments;
      end else if (pending_flag) begin
        shadow_next = pending;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      pending_flag <= 1'b0;
      shadow       <= '0;
    end else begin
      shadow <= shadow_next;
      if (in_valid) begin
        pending <= in_segments;
      end
      if (frame_first) begin
        pending_flag <= 1'b0;
      end else if (in_valid) begin
        pending_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    seg_sel   = shadow_next[{idx, 3'b000} +: 8];
    digit_sel = w_digit'(1) << idx;
`ifdef SEVEN_SEG_GHOST_BLANK_EN
    show      = enable && (cnt >= cnt_w'(blank_cycles));
`else
    show      = enable;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abcdefgh    <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      abcdefgh    <= show ? seg_sel : 8'h00;
      digit       <= show ? digit_sel : '0;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios plus random loads,
// all compared against a time-indexed reference model of the scan.
module tb_seven_segment_scanner;

  localparam int W     = 4;
  localparam int S     = 4;
  localparam int P     = W * S;
  localparam int BLANK = 1;

  logic           clk;
  logic           rst;
  logic [W*8-1:0] in_segments;
  logic           in_valid;
  logic           enable;
  logic [7:0]     abcdefgh;
  logic [W-1:0]   digit;
  logic           frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_scanner #(
    .clk_mhz(1), .w_digit(W), .slot_khz(250), .blank_cycles(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .in_segments(in_segments), .in_valid(in_valid),
    .enable(enable), .abcdefgh(abcdefgh), .digit(digit), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: output at edge t (counted from reset release) shows position t mod P.
  int         m_t;
  int         m_pos;
  int         m_slot;
  int         m_phase;
  bit         m_have;
  bit         m_lit;
  logic [7:0] m_frame [W];
  logic [7:0] m_pend  [W];
  logic [7:0] exp_seg;
  logic [W-1:0] exp_dig;
  logic       exp_fs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0;
      m_have = 0;
      for (int i = 0; i < W; i++) begin
        m_frame[i] = 8'h00;
        m_pend[i]  = 8'h00;
      end
      exp_seg = 8'h00;
      exp_dig = '0;
      exp_fs  = 1'b0;
    end else begin
      m_pos   = m_t % P;
      m_slot  = m_pos / S;
      m_phase = m_pos % S;
      if (m_pos == 0) begin
        if (in_valid) begin
          for (int i = 0; i < W; i++) m_frame[i] = in_segments[8*i +: 8];
        end else if (m_have) begin
          for (int i = 0; i < W; i++) m_frame[i] = m_pend[i];
        end
        m_have = 0;
      end else if (in_valid) begin
        for (int i = 0; i < W; i++) m_pend[i] = in_segments[8*i +: 8];
        m_have = 1;
      end
      m_lit = enable;
`ifdef SEVEN_SEG_GHOST_BLANK_EN
      if (m_phase < BLANK) m_lit = 0;
`endif
      exp_dig = m_lit ? W'(1 << m_slot) : '0;
      exp_seg = m_lit ? m_frame[m_slot] : 8'h00;
      exp_fs  = (m_pos == 0);
      m_t++;
    end
  end

  task automatic do_reset(input logic [W*8-1:0] first_frame, input logic load_first);
    rst = 1'b1;
    in_valid = 1'b0;
    enable = 1'b1;
    in_segments = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = load_first;
    in_segments = first_frame;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0;
    enable = 1'b1;
    in_segments = '0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (abcdefgh !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_seg: got %h want 00", abcdefgh);
    end
    n_checks++;
    if (digit !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_digit: got %b want 0000", digit);
    end
    n_checks++;
    if (frame_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_fs: got %b want 0", frame_start);
    end
  endtask

  task automatic test_reset_scan;
    logic [W-1:0] want_dig;
    logic         want_fs;
    do_reset('0, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL scan_model c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      want_dig = W'(1 << (((c - 1) / S) % W));
`ifdef SEVEN_SEG_GHOST_BLANK_EN
      if (((c - 1) % S) < BLANK) want_dig = '0;
`endif
      want_fs = (c == 1) || (c == 17) || (c == 33);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {want_fs, want_dig, 8'h00}) begin
        n_fail++;
        $display("[TB] FAIL scan_plan c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=00", c, frame_start, digit, abcdefgh, want_fs, want_dig);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_mid_frame_load;
    logic [7:0] pats [W];
    pats[0] = 8'hEE; pats[1] = 8'hBC; pats[2] = 8'hCE; pats[3] = 8'h8E;
    do_reset('0, 1'b0);
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL midload_model c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      if (c > 5 && c <= 16) begin
        n_checks++;
        if (abcdefgh !== 8'h00) begin
          n_fail++;
          $display("[TB] FAIL midload_early c%0d: got seg=%h want 00", c, abcdefgh);
        end
      end
      if (c >= 18 && c <= 30 && ((c - 18) % S) == 0) begin
        n_checks++;
        if ({digit, abcdefgh} !== {W'(1 << ((c - 18) / S)), pats[(c - 18) / S]}) begin
          n_fail++;
          $display("[TB] FAIL midload_show c%0d: got dig=%b seg=%h want dig=%b seg=%h", c, digit, abcdefgh, W'(1 << ((c - 18) / S)), pats[(c - 18) / S]);
        end
      end
      in_valid = (c == 5);
      in_segments = 32'h8ECEBCEE;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_last_wins_bypass;
    do_reset('0, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL lastwins_model c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      if (c == 18 || c == 30) begin
        n_checks++;
        if (abcdefgh !== 8'h22) begin
          n_fail++;
          $display("[TB] FAIL lastwins_show c%0d: got seg=%h want 22", c, abcdefgh);
        end
      end
      if (c == 34) begin
        n_checks++;
        if ({digit, abcdefgh} !== {W'(1), 8'h33}) begin
          n_fail++;
          $display("[TB] FAIL bypass_show c%0d: got dig=%b seg=%h want dig=0001 seg=33", c, digit, abcdefgh);
        end
      end
      in_valid = (c == 3) || (c == 9) || (c == 32);
      in_segments = (c == 3) ? 32'h11111111 : (c == 9) ? 32'h22222222 : 32'h33333333;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_enable;
    do_reset(32'h8ECEBCEE, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL enable_model c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      if (c >= 7 && c <= 11) begin
        n_checks++;
        if ({digit, abcdefgh} !== {W'(0), 8'h00}) begin
          n_fail++;
          $display("[TB] FAIL enable_dark c%0d: got dig=%b seg=%h want dig=0000 seg=00", c, digit, abcdefgh);
        end
      end
      if (c == 12) begin
        n_checks++;
        if ({digit, abcdefgh} !== {W'(4), 8'hCE}) begin
          n_fail++;
          $display("[TB] FAIL enable_reentry: got dig=%b seg=%h want dig=0100 seg=CE", digit, abcdefgh);
        end
      end
      if (c == 17) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL enable_fs: got %b want 1", frame_start);
        end
      end
      in_valid = 1'b0;
      enable = !(c >= 6 && c <= 10);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    do_reset(32'h8ECEBCEE, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL rstmid_pre c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      in_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({frame_start, digit, abcdefgh} !== {1'b0, W'(0), 8'h00}) begin
      n_fail++;
      $display("[TB] FAIL rstmid_async: got fs=%b dig=%b seg=%h want all zero", frame_start, digit, abcdefgh);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL rstmid_post c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      n_checks++;
      if (abcdefgh !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL rstmid_cleared c%0d: got seg=%h want 00", c, abcdefgh);
      end
      if (c == 2) begin
        n_checks++;
        if (digit !== W'(1)) begin
          n_fail++;
          $display("[TB] FAIL rstmid_restart: got dig=%b want 0001", digit);
        end
      end
    end
  endtask

  task automatic test_random;
    do_reset('0, 1'b0);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {exp_fs, exp_dig, exp_seg}) begin
        n_fail++;
        $display("[TB] FAIL random c%0d: got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h", c, frame_start, digit, abcdefgh, exp_fs, exp_dig, exp_seg);
      end
      in_valid = ($urandom_range(0, 7) == 0);
      in_segments = $urandom;
      enable = ($urandom_range(0, 9) != 0);
    end
    in_valid = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    test_reset;
    test_reset_scan;
    test_mid_frame_load;
    test_last_wins_bypass;
    test_enable;
    test_reset_mid_frame;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
